// File: rtl/fix_lut_p.sv
// Shared types and elaboration helpers for the cumulative ±fact LUT accumulator.
package fix_lut_p;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // hi/lo say which bound the clamped result must take; both stay 0 in wrap mode
  typedef struct packed {
    logic ovf;
    logic hi;
    logic lo;
  } clamp_t;

  localparam int CLAMP_W = 64;

  function automatic int lut_count(input int size, input int lut_size);
    return (size + lut_size - 1) / lut_size;
  endfunction

  function automatic int step_count(input int luts, input int per_step);
    return (luts + per_step - 1) / per_step;
  endfunction

  function automatic int acc_width(input int n_int, input int n_mant, input int guard,
                                   input int luts);
    return n_int + n_mant + 1 + guard + $clog2(luts);
  endfunction

  function automatic clamp_t sat_clamp(input logic signed [CLAMP_W-1:0] acc, input int res_w,
                                       input bit sat);
    logic signed [CLAMP_W-1:0] lo;
    logic signed [CLAMP_W-1:0] hi;
    clamp_t                    c;
    lo    = -(64'sd1 <<< (res_w - 1));
    hi    = -lo - 64'sd1;
    c.hi  = acc > hi;
    c.lo  = acc < lo;
    c.ovf = c.hi | c.lo;
    if (!sat) begin
      c.hi = 1'b0;
      c.lo = 1'b0;
    end
    return c;
  endfunction

endpackage

// File: rtl/fix_lut_accum_if.sv
// Select-word input and result output handshakes of the LUT accumulator.
interface fix_lut_accum_if #(
  parameter int SIZE  = 12,
  parameter int RES_W = 32
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic [SIZE-1:0]         sel;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [RES_W-1:0] result;
  logic                    overflow;

  modport master (
    output in_valid, sel, out_ready,
    input  in_ready, out_valid, result, overflow
  );

  modport slave (
    input  in_valid, sel, out_ready,
    output in_ready, out_valid, result, overflow
  );
endinterface

// File: rtl/fix_lut_rom.sv
// Combinational 2^SIZE-entry LUT: entry a = sum over j of (a[j] ? +FACT[j] : -FACT[j]).
module fix_lut_rom #(
  parameter int SIZE   = 6,
  parameter int N_INT  = 8,
  parameter int N_MANT = 23,
  parameter int OUT_W  = 37,
  parameter logic [SIZE*(N_INT+N_MANT+1)-1:0] FACT = '0
) (
  input  logic [SIZE-1:0]         addr,
  output logic signed [OUT_W-1:0] data
);
  localparam int FW    = N_INT + N_MANT + 1;
  localparam int DEPTH = 2 ** SIZE;

  function automatic logic signed [OUT_W-1:0] entry(input int a);
    logic signed [OUT_W-1:0] s;
    logic signed [OUT_W-1:0] f;
    s = '0;
    for (int j = 0; j < SIZE; j++) begin
      f = OUT_W'($signed(FW'(FACT >> (j * FW))));
      if (((a >> j) & 1) != 0) s = s + f;
      else                     s = s - f;
    end
    return s;
  endfunction

  logic signed [OUT_W-1:0] rom [DEPTH];

  for (genvar a = 0; a < DEPTH; a++) begin : g_ent
    assign rom[a] = entry(a);
  end

  assign data = rom[addr];

endmodule

// File: rtl/fix_lut_accum.sv
// Handshaked cumulative ±fact LUT sum: LUT_PER_STEP slices per clock, saturated or wrapped result.
module fix_lut_accum
  import fix_lut_p::*;
#(
  parameter int SIZE         = 12,
  parameter int LUT_SIZE     = 6,
  parameter int LUT_PER_STEP = 1,
  parameter int N_INT        = 8,
  parameter int N_MANT       = 23,
  parameter int GUARD        = 4,
  parameter bit SATURATE     = 1'b1,
  parameter logic signed [SIZE-1:0][N_INT+N_MANT:0] FACT = '0
) (
  input logic             clk,
  input logic             rst_n,
  fix_lut_accum_if.slave  bus
);
  localparam int FW     = N_INT + N_MANT + 1;
  localparam int LUTS   = lut_count(SIZE, LUT_SIZE);
  localparam int STEPS  = step_count(LUTS, LUT_PER_STEP);
  localparam int ACC_W  = acc_width(N_INT, N_MANT, GUARD, LUTS);
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int SLOTS  = LUT_PER_STEP * STEPS;
  localparam logic [SIZE*FW-1:0] FACT_FLAT = FACT;

  state_t state, state_nx;
  logic   rdy, load, step_en, fin;

  logic [SIZE-1:0]         sel_p0;
  logic signed [ACC_W-1:0] acc_p0;
  logic [STEP_W-1:0]       step_p0;
  logic signed [FW-1:0]    result_p1;
  logic                    ovf_p1;

  logic signed [ACC_W-1:0] step_sum, acc_nx;
  logic signed [FW-1:0]    res_nx;
  clamp_t                  clamp_nx;

  // ---- stage 0: slice LUTs, step-selected slot sum, accumulator ----
  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    logic signed [ACC_W-1:0] val;
    logic signed [ACC_W-1:0] part;
    logic                    hit;

    if (i < LUTS) begin : g_lut
      // the last slice is narrower when SIZE is not a multiple of LUT_SIZE
      localparam int W = (SIZE - i * LUT_SIZE < LUT_SIZE) ? (SIZE - i * LUT_SIZE) : LUT_SIZE;
      fix_lut_rom #(
        .SIZE   (W),
        .N_INT  (N_INT),
        .N_MANT (N_MANT),
        .OUT_W  (ACC_W),
        .FACT   (FACT_FLAT[i*LUT_SIZE*FW +: W*FW])
      ) u_rom (
        .addr (sel_p0[i*LUT_SIZE +: W]),
        .data (val)
      );
    end else begin : g_pad
      assign val = '0;
    end

    assign hit = (step_p0 == STEP_W'(i / LUT_PER_STEP));

    if (i == 0) begin : g_first
      assign part = hit ? val : '0;
    end else begin : g_next
      assign part = g_slot[i-1].part + (hit ? val : '0);
    end
  end

  assign step_sum = g_slot[SLOTS-1].part;
  assign acc_nx   = acc_p0 + step_sum;
  assign clamp_nx = sat_clamp(CLAMP_W'(acc_nx), FW, SATURATE);
  assign res_nx   = clamp_nx.hi ? {1'b0, {(FW-1){1'b1}}} :
                    clamp_nx.lo ? {1'b1, {(FW-1){1'b0}}} :
                    acc_nx[FW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rdy      = 1'b0;
    load     = 1'b0;
    step_en  = 1'b0;
    fin      = 1'b0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (bus.in_valid) begin
          load     = 1'b1;
          state_nx = ACCUM;
        end
      end
      ACCUM: begin
        step_en = 1'b1;
        if (step_p0 == STEP_W'(STEPS - 1)) begin
          fin      = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        // completing handshake frees the block, so a new sel can enter on the same edge
        if (bus.out_ready) begin
          rdy = 1'b1;
          if (bus.in_valid) begin
            load     = 1'b1;
            state_nx = ACCUM;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_p0  <= '0;
      acc_p0  <= '0;
      step_p0 <= '0;
    end else if (load) begin
      sel_p0  <= bus.sel;
      acc_p0  <= '0;
      step_p0 <= '0;
    end else if (step_en) begin
      acc_p0  <= acc_nx;
      step_p0 <= fin ? '0 : step_p0 + STEP_W'(1);
    end
  end

  // ---- stage 1: registered result, held through DONE ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_p1 <= '0;
      ovf_p1    <= 1'b0;
    end else if (fin) begin
      result_p1 <= res_nx;
      ovf_p1    <= clamp_nx.ovf;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_p1;
  assign bus.overflow  = ovf_p1;

endmodule

// File: tb/tb_fix_lut_accum.sv
// Bench for fix_lut_accum: four configurations driven in lockstep from one stimulus.
module tb_fix_lut_accum;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid, out_ready;
  logic [4:0] sel5;
  bit         mon_en = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  fix_lut_accum_if #(.SIZE(4), .RES_W(8)) if_a ();
  fix_lut_accum_if #(.SIZE(4), .RES_W(8)) if_s1 ();
  fix_lut_accum_if #(.SIZE(4), .RES_W(8)) if_s0 ();
  fix_lut_accum_if #(.SIZE(5), .RES_W(8)) if_r ();

  assign if_a.in_valid  = in_valid;  assign if_a.out_ready  = out_ready;  assign if_a.sel  = sel5[3:0];
  assign if_s1.in_valid = in_valid;  assign if_s1.out_ready = out_ready;  assign if_s1.sel = sel5[3:0];
  assign if_s0.in_valid = in_valid;  assign if_s0.out_ready = out_ready;  assign if_s0.sel = sel5[3:0];
  assign if_r.in_valid  = in_valid;  assign if_r.out_ready  = out_ready;  assign if_r.sel  = sel5;

  fix_lut_accum #(.SIZE(4), .LUT_SIZE(2), .LUT_PER_STEP(1), .N_INT(3), .N_MANT(4), .GUARD(4),
                  .SATURATE(1'b1), .FACT(32'h02_04_08_10))
    u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  fix_lut_accum #(.SIZE(4), .LUT_SIZE(2), .LUT_PER_STEP(1), .N_INT(3), .N_MANT(4), .GUARD(4),
                  .SATURATE(1'b1), .FACT(32'h64_64_64_64))
    u_s1 (.clk(clk), .rst_n(rst_n), .bus(if_s1));
  fix_lut_accum #(.SIZE(4), .LUT_SIZE(2), .LUT_PER_STEP(1), .N_INT(3), .N_MANT(4), .GUARD(4),
                  .SATURATE(1'b0), .FACT(32'h64_64_64_64))
    u_s0 (.clk(clk), .rst_n(rst_n), .bus(if_s0));
  fix_lut_accum #(.SIZE(5), .LUT_SIZE(2), .LUT_PER_STEP(2), .N_INT(3), .N_MANT(4), .GUARD(4),
                  .SATURATE(1'b1), .FACT(40'h10_08_04_02_01))
    u_r (.clk(clk), .rst_n(rst_n), .bus(if_r));

  // Reference: dut 0 facts 16,8,4,2; duts 1/2 all 100 (sat / wrap); dut 3 facts 1,2,4,8,16.
  function automatic int ideal(input int d, input logic [4:0] s);
    int sum = 0;
    int nb = (d == 3) ? 5 : 4;
    for (int j = 0; j < nb; j++) begin
      int f = (d == 0) ? (16 >> j) : (d == 3) ? (1 << j) : 100;
      sum += (((s >> j) & 1) != 0) ? f : -f;
    end
    return sum;
  endfunction

  function automatic int fit(input int v, input bit sat);
    if (sat) return (v > 127) ? 127 : (v < -128) ? -128 : v;
    return ((v & 255) > 127) ? (v & 255) - 256 : (v & 255);
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  typedef struct {
    logic [4:0] sel;
    int a; int s1; int o1; int s0; int o0; int r;
  } vec_t;

  vec_t vec [6];

  task automatic check_out(input vec_t v, input string tag);
    chk({tag, " A res"},  int'(if_a.result),  v.a);
    chk({tag, " A ovf"},  int'(if_a.overflow), 0);
    chk({tag, " S1 res"}, int'(if_s1.result), v.s1);
    chk({tag, " S1 ovf"}, int'(if_s1.overflow), v.o1);
    chk({tag, " S0 res"}, int'(if_s0.result), v.s0);
    chk({tag, " S0 ovf"}, int'(if_s0.overflow), v.o0);
    chk({tag, " R res"},  int'(if_r.result),  v.r);
    chk({tag, " R ovf"},  int'(if_r.overflow), 0);
  endtask

  // Called #1 after an edge in IDLE with out_ready=1; leaves the block back in IDLE.
  task automatic run_vec(input vec_t v, input string tag);
    in_valid = 1'b1; sel5 = v.sel;
    @(posedge clk); #1;
    in_valid = 1'b0; sel5 = ~v.sel;
    chk({tag, " vld after accept"}, int'(if_a.out_valid), 0);
    @(posedge clk); #1;
    chk({tag, " vld edge1"}, int'(if_a.out_valid), 0);
    @(posedge clk); #1;
    chk({tag, " vld edge2 A"}, int'(if_a.out_valid), 1);
    chk({tag, " vld edge2 R"}, int'(if_r.out_valid), 1);
    check_out(v, tag);
    @(posedge clk); #1;
  endtask

  // Scoreboard for the randomised phase, one queue of accepted selects per DUT.
  logic [4:0] selq [4][$];
  int n_acc [4];
  int n_out [4];

  task automatic mon(input int d, input logic rdy, input logic vld,
                     input logic signed [7:0] res, input logic ovf);
    logic [4:0] s;
    int e;
    if (vld && out_ready) begin
      if (selq[d].size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rand dut%0d unexpected output: got result %0d, required no output", d, res);
      end else begin
        s = selq[d].pop_front();
        e = ideal(d, s);
        chk($sformatf("rand dut%0d res sel=%b", d, s), int'(res), fit(e, d != 2));
        chk($sformatf("rand dut%0d ovf sel=%b", d, s), int'(ovf), (e > 127 || e < -128) ? 1 : 0);
        n_out[d]++;
      end
    end
    if (in_valid && rdy) begin
      selq[d].push_back(sel5);
      n_acc[d]++;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      mon(0, if_a.in_ready,  if_a.out_valid,  if_a.result,  if_a.overflow);
      mon(1, if_s1.in_ready, if_s1.out_valid, if_s1.result, if_s1.overflow);
      mon(2, if_s0.in_ready, if_s0.out_valid, if_s0.result, if_s0.overflow);
      mon(3, if_r.in_ready,  if_r.out_valid,  if_r.result,  if_r.overflow);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    vec[0] = '{5'b01111,  30,  127, 1, -112, 1,  -1};
    vec[1] = '{5'b00000, -30, -128, 1,  112, 1, -31};
    vec[2] = '{5'b00101,  10,    0, 0,    0, 0, -21};
    vec[3] = '{5'b10000, -30, -128, 1,  112, 1,   1};
    vec[4] = '{5'b10011,  18,    0, 0,    0, 0,   7};
    vec[5] = '{5'b00111,  26,  127, 1,  -56, 1, -17};
    for (int d = 0; d < 4; d++) begin n_acc[d] = 0; n_out[d] = 0; end

    in_valid = 1'b0; out_ready = 1'b1; sel5 = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset A in_ready", int'(if_a.in_ready), 1);
    chk("reset A out_valid", int'(if_a.out_valid), 0);
    chk("reset A result", int'(if_a.result), 0);
    chk("reset A overflow", int'(if_a.overflow), 0);
    chk("reset R out_valid", int'(if_r.out_valid), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_vec(vec[i], $sformatf("vec%0d", i));

    // Backpressure: result held for 5 stalled cycles, then back-to-back accept
    out_ready = 1'b0; in_valid = 1'b1; sel5 = 5'b01111;
    @(posedge clk); #1;
    sel5 = 5'b10011;
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d vld", c), int'(if_a.out_valid), 1);
      chk($sformatf("stall%0d res", c), int'(if_a.result), 30);
      chk($sformatf("stall%0d S1 ovf", c), int'(if_s1.overflow), 1);
      chk($sformatf("stall%0d in_ready", c), int'(if_a.in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1; #1;
    chk("release in_ready", int'(if_a.in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b vld after accept", int'(if_a.out_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("b2b vld", int'(if_a.out_valid), 1);
    check_out(vec[4], "b2b");
    @(posedge clk); #1;

    // Reset one cycle into ACCUM, then a clean transaction
    in_valid = 1'b1; sel5 = 5'b00000;
    @(posedge clk); #1;
    in_valid = 1'b0; rst_n = 1'b0; #1;
    chk("rst accum out_valid", int'(if_a.out_valid), 0);
    chk("rst accum in_ready", int'(if_a.in_ready), 1);
    @(posedge clk); #1 rst_n = 1'b1;
    run_vec(vec[0], "post-reset");

    // Reset while holding a result in DONE drops out_valid at once
    out_ready = 1'b0; in_valid = 1'b1; sel5 = 5'b00101;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("done before rst vld", int'(if_a.out_valid), 1);
    rst_n = 1'b0; #1;
    chk("rst done out_valid", int'(if_a.out_valid), 0);
    chk("rst done result", int'(if_a.result), 0);
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;

    // Randomised traffic with stalls against the scoreboard
    mon_en = 1'b1;
    cyc = 0;
    while (n_acc[0] < 1000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      sel5      = 5'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 20000) begin
      n_checks++; n_fail++;
      $display("FAIL rand budget: got %0d accepted, required 1000", n_acc[0]);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    mon_en = 1'b0;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("dut%0d pending after drain", d), selq[d].size(), 0);
      chk($sformatf("dut%0d outputs vs accepts", d), n_out[d], n_acc[d]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fix_lut_accum.md
Name: fix_lut_accum

Overview:
- Handshaked, resettable successor to the cumulative fixed-point LUT.
- Splits a SIZE-bit select word into LUT_SIZE-bit slices, each addressing a ±fact sum LUT.
- Evaluates LUT_PER_STEP slices per clock and accumulates over STEPS cycles in a guard-bit accumulator.
- Emits a saturated or wrapped result with overflow flag on a valid/ready output. Sits between the control-bit shift registers and the filter output stage.

Parameters:
- SIZE, 12, number of select bits / factors
- LUT_SIZE, 6, select bits per LUT slice (max 8)
- LUT_PER_STEP, 1, slices summed per clock (power of two)
- N_INT, 8, integer bits (excluding sign)
- N_MANT, 23, fractional bits
- GUARD, 4, extra accumulator MSBs
- SATURATE, 1, 1 = clamp result on overflow, 0 = two's-complement wrap
- FACT, 0, signed [SIZE-1:0][N_INT+N_MANT:0] factor array

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  async active-low reset
- in_valid  in  1  sel valid
- in_ready  out  1  block can accept sel
- sel  in  SIZE  select word; bit j=1 adds FACT[j], 0 subtracts it
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  N_INT+N_MANT+1  signed fixed-point sum
- overflow  out  1  accumulator exceeded result range (valid with out_valid)

Behaviour:
- Derived constants: LUTS = ceil(SIZE/LUT_SIZE); STEPS = ceil(LUTS/LUT_PER_STEP); ACC_W = N_INT+N_MANT+1+GUARD+clog2(LUTS).
- Last slice holds SIZE mod LUT_SIZE bits when nonzero. Slots beyond LUTS in the final step contribute exactly 0.
- Reset (rst_n=0, async): state=IDLE, in_ready=1, out_valid=0, result=0, overflow=0, accumulator=0, step=0, captured sel=0.
- FSM states: IDLE, ACCUM, DONE.
  - IDLE: in_ready=1. When in_valid, capture sel, clear accumulator, step=0, go to ACCUM.
  - ACCUM: in_ready=0. Each edge: acc += sign-extended sum of slices [step*LUT_PER_STEP +: LUT_PER_STEP]; step++. After the edge with step==STEPS-1, go to DONE.
  - DONE: out_valid=1.
    - result = acc clamped to [-2^(N_INT+N_MANT), 2^(N_INT+N_MANT)-1] if SATURATE, else acc[N_INT+N_MANT:0].
    - overflow = 1 iff acc lies outside that range, in either mode.
    - result and overflow are registered and held stable until out_ready.
  - DONE with out_ready=1: handshake completes. in_ready is combinationally 1 in this case.
    - If in_valid is also 1, capture the new sel and go directly to ACCUM (back-to-back, no bubble).
    - Otherwise go to IDLE.
  - DONE with out_ready=0: hold state and all outputs; in_ready=0.
- Latency: out_valid rises STEPS edges after the accepting edge. Throughput is one result per STEPS+1 cycles if out_ready stays high.
- Arithmetic: all sums are signed two's complement. No overflow is possible inside ACC_W. LUT contents are computed at elaboration.
- STEPS==1: ACCUM lasts one edge.
- sel changes while not accepted: ignored; only the captured copy is used.
- Reset mid-ACCUM or mid-DONE: immediate return to IDLE; the partial result is discarded and out_valid drops asynchronously.

Decomposition:
- Package fix_lut_p:
  - state enum (IDLE/ACCUM/DONE)
  - elaboration functions lut_count, step_count, acc_width
  - sat_clamp function (ACC_W to result width, also returns overflow)
- Sub-module fix_lut_rom #(size, n_int, n_mant, fact):
  - combinational 2^size-entry ±fact LUT
  - instantiated LUTS times with zero padding to LUT_PER_STEP*STEPS slots
  - slot mux indexed by step

Test Plan:
- SIZE=4, LUT_SIZE=2, LUT_PER_STEP=1, N_INT=3, N_MANT=4, FACT={16,8,4,2} (fact[0]=16), out_ready=1:
  - sel=4'b1111 -> result=30, overflow=0, out_valid 2 edges after accept.
  - sel=4'b0000 -> result=-30.
  - sel=4'b0101 -> result=16-8+4-2=10.
- Saturation: FACT all 100, sel=4'b1111 -> SATURATE=1: result=127, overflow=1. SATURATE=0: result=-112 (400 mod 256), overflow=1. sel=0 with SATURATE=1 -> result=-128, overflow=1.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, result and overflow held, in_ready=0. Then out_ready=1 with in_valid=1 and sel=4'b0011 -> accepted the same edge; next result=18 after 2 more edges.
- Ragged last slice: SIZE=5, LUT_SIZE=2, LUT_PER_STEP=2, FACT={1,2,4,8,16}, sel=5'b10000 -> STEPS=2, result=16-15=1.
- Reset: drive rst_n low one cycle into ACCUM -> out_valid=0, in_ready=1 immediately. A following sel=4'b1111 yields 30 with no residue from the aborted sum.
- Randomised: 1000 random sel values with random out_ready stalls -> each result equals the reference model's ±FACT sum (clamped per SATURATE); no accepted input is lost or duplicated.
